decay_scheduler: RTL
====================

// Module: decay_scheduler
// PURPOSE
//  Time-shares one potential_decay unit across NUM_NEURONS membrane potentials held in a shared potential memory.
//  On each timestep pulse it sweeps neuron indices 0..NUM_NEURONS-1: read potential, apply decay at that neuron's rate, write back.
//  Holds the per-neuron decay_rate config table, and yields memory cycles to other requesters through a grant input.
// PARAMETERS
//  NUM_NEURONS  16  neurons swept per timestep (>=2)
//  ADDR_W       4   memory/config index width; 2**ADDR_W >= NUM_NEURONS
//  DECAY_LAT    1   cycles from decay_in stable to decay_out valid (>=1)
// PORTS
//  CLK          in   1       clock; all state changes on posedge
//  RESET        in   1       asynchronous, active-high reset
//  start        in   1       timestep pulse; sampled only in IDLE
//  busy         out  1       high from the cycle after start is accepted until DONE ends
//  done         out  1       one-cycle pulse when the sweep completes
//  cfg_we       in   1       write cfg_rate into the rate table at cfg_addr
//  cfg_addr     in   ADDR_W  rate-table index
//  cfg_rate     in   3       decay rate; 0 = neuron not decayed
//  mem_grant    in   1       memory arbiter grant for this cycle
//  mem_rd_en    out  1       read request
//  mem_wr_en    out  1       write request
//  mem_addr     out  ADDR_W  current neuron index
//  mem_rd_data  in   32      IEEE-754 potential, valid the cycle after a granted read
//  mem_wr_data  out  32      decayed potential
//  decay_rate   out  3       to potential_decay
//  decay_in     out  32      to potential_decay; registered
//  decay_out    in   32      from potential_decay
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, idx=0, all outputs 0, rate table all 0.
//   - Reset mid-sweep aborts. A write whose grant cycle has completed stays in memory; no partial write.
//  States: IDLE, READ, WAIT, DECAY, WRITE, DONE.
//   - IDLE:  start=1 -> READ, idx=0, busy=1.
//   - READ:  if rate[idx]==0: no request; go to NEXT (1 cycle, memory untouched).
//            else drive mem_rd_en=1, mem_addr=idx. Grant -> WAIT; no grant -> stay, request held.
//   - WAIT:  latch mem_rd_data into decay_in; decay_rate=rate[idx]; count=0 -> DECAY.
//   - DECAY: hold decay_in/decay_rate for DECAY_LAT cycles. At end, capture decay_out into mem_wr_data -> WRITE.
//   - WRITE: drive mem_wr_en=1, mem_addr=idx. No grant -> stay, request held. Grant -> NEXT.
//   - NEXT (transition, not a state): idx==NUM_NEURONS-1 -> DONE; else idx+1 -> READ.
//   - DONE:  done=1, busy=0 for exactly one cycle -> IDLE; idx=0.
//  Request rules:
//   - mem_rd_en and mem_wr_en are never high together.
//   - A request stays asserted with a stable address until granted.
//  Latency: a granted neuron takes 3+DECAY_LAT cycles; a skipped neuron takes 1 cycle.
//   - Full sweep with continuous grant: sum over neurons + 1 (DONE).
//  Config table:
//   - cfg_we is accepted in any state.
//   - rate[idx] is sampled in READ and again in WAIT. A write to the current idx after WAIT affects the next sweep only.
//   - Same-cycle cfg write and READ sample of the same idx: READ sees the old value.
//  Other rules:
//   - start while busy is ignored (no queueing).
//   - start in the DONE cycle is ignored.
//   - Potentials pass through unmodified except via decay_out; no arithmetic in this block.
// TESTING
//  1. Rates all 3, grant=1, NUM_NEURONS=4, DECAY_LAT=1; bench decay_out=decay_in+1.
//     mem[0]=32'h40E00000, start -> mem[0]=32'h40E00001, same for all 4; done pulses 17 cycles after start.
//  2. rate[1]=0, others 3 -> mem[1] unchanged, no rd/wr at addr 1; done at cycle 14.
//  3. Drop grant for 5 cycles while mem_rd_en is high on idx 2 -> request and addr held; results identical; done 5 cycles later.
//  4. start pulsed mid-sweep and in the DONE cycle -> ignored; exactly one done pulse.
//  5. RESET asserted while in DECAY for idx 1 -> outputs 0 at once; mem[1] unmodified; rate table cleared.
//  6. cfg_we rate[3]=0 while processing idx 1 -> idx 3 skipped this sweep.

Source files
------------

// File: rtl/decay_scheduler.sv
// decay_scheduler: sweeps all neurons once per timestep pulse, reading each
// membrane potential, passing it through a shared potential_decay unit at that
// neuron's configured rate, and writing the result back. Memory access is
// arbitrated externally; every request is held (with a stable address) until
// mem_grant is seen in the same cycle.
module decay_scheduler #(
   parameter int NUM_NEURONS = 16,
   parameter int ADDR_W      = 4,
   parameter int DECAY_LAT   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [2:0]        cfg_rate,
   input  logic              mem_grant,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rd_data,
   output logic [31:0]       mem_wr_data,
   output logic [2:0]        decay_rate,
   output logic [31:0]       decay_in,
   input  logic [31:0]       decay_out
);

   // The rate table spans the full address space so any cfg_addr can be
   // written; entries at or beyond NUM_NEURONS are simply never swept.
   localparam int TBL_N = 1 << ADDR_W;
   localparam int CNT_W = (DECAY_LAT > 1) ? $clog2(DECAY_LAT) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DECAY_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WAIT  = 3'd2,
      S_DECAY = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [31:0]             din_q, din_d;
   logic [2:0]              drate_q, drate_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [TBL_N-1:0][2:0]   rate_q, rate_d;

   logic [2:0]              cur_rate;
   logic                    advance;
   logic                    rd_req;
   logic                    wr_req;

   // Registered table: a same-cycle cfg write is not visible to the READ/WAIT
   // sample until the following cycle.
   assign cur_rate = rate_q[idx_q];

   // Rate table update; writes accepted in every state.
   always_comb begin
      rate_d = rate_q;
      if (cfg_we) begin
         rate_d[cfg_addr] = cfg_rate;
      end
   end

   // Sweep sequencer: next state, datapath captures and memory requests.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      din_d   = din_q;
      drate_d = drate_q;
      wdata_d = wdata_q;
      rd_req  = 1'b0;
      wr_req  = 1'b0;
      advance = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_READ;
               idx_d   = '0;
            end
         end
         S_READ: begin
            // Rate 0 means the neuron is left alone: no memory traffic at all.
            if (cur_rate == 3'd0) begin
               advance = 1'b1;
            end else begin
               rd_req = 1'b1;
               if (mem_grant) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Read data arrives the cycle after the granted read.
            din_d   = mem_rd_data;
            drate_d = cur_rate;
            cnt_d   = '0;
            state_d = S_DECAY;
         end
         S_DECAY: begin
            if (cnt_q == LAST_CNT) begin
               wdata_d = decay_out;
               state_d = S_WRITE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WRITE: begin
            wr_req = 1'b1;
            if (mem_grant) begin
               advance = 1'b1;
            end
         end
         S_DONE: begin
            // start is deliberately not looked at here.
            state_d = S_IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase

      // Move to the next neuron, or finish after the last one.
      if (advance) begin
         if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
         end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
         end
      end
   end

   // State, datapath and config registers; reset aborts any sweep.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         din_q   <= '0;
         drate_q <= '0;
         wdata_q <= '0;
         rate_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         drate_q <= drate_d;
         wdata_q <= wdata_d;
         rate_q  <= rate_d;
      end
   end

   // Outputs decode straight from registered state, so reset clears them at once.
   assign busy        = (state_q == S_READ) || (state_q == S_WAIT) ||
                        (state_q == S_DECAY) || (state_q == S_WRITE);
   assign done        = (state_q == S_DONE);
   assign mem_rd_en   = rd_req;
   assign mem_wr_en   = wr_req;
   assign mem_addr    = (rd_req || wr_req) ? idx_q : '0;
   assign mem_wr_data = wdata_q;
   assign decay_rate  = drate_q;
   assign decay_in    = din_q;

endmodule
